// File: rtl/tlb_unit.sv
// tlb_unit: fully associative TLB, 20-bit VPN -> 20-bit PPN, 4 KiB pages.
// Lookup is combinational; fills are synchronous with round-robin (FIFO)
// replacement. A write to a VPN already present updates that entry in place,
// so the table never holds duplicate VPNs.
// Optional build macro: TLB_DIRTY_OUT_EN adds the tlb_dirty output.

// One TLB slot: holds the translation and reports matches against both the
// lookup VPN and the incoming write VPN.
module tlb_entry (
    input  logic        clk,
    input  logic        reset,
    input  logic        alloc,
    input  logic        update,
    input  logic [19:0] wr_vpn,
    input  logic [19:0] wr_ppn,
    input  logic        wr_dirty,
    input  logic [19:0] lk_vpn,
    output logic        lk_match,
    output logic        wr_match,
    output logic [19:0] ppn_q,
    output logic        dirty_q
);
    typedef struct packed {
        logic        valid;
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic        dirty;
    } entry_t;

    entry_t ent;

    // Fill (new VPN) or in-place update (existing VPN); reset wins over both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent <= '0;
        end else if (alloc) begin
            ent.valid <= 1'b1;
            ent.vpn   <= wr_vpn;
            ent.ppn   <= wr_ppn;
            ent.dirty <= wr_dirty;
        end else if (update) begin
            ent.ppn   <= wr_ppn;
            ent.dirty <= wr_dirty;
        end
    end

    assign lk_match = ent.valid && (ent.vpn == lk_vpn);
    assign wr_match = ent.valid && (ent.vpn == wr_vpn);
    assign ppn_q    = ent.ppn;
    assign dirty_q  = ent.dirty;
endmodule

module tlb_unit #(
    parameter int ENTRIES = 8,
    parameter int PTR_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [19:0] virtual_page_number,
    input  logic [19:0] physical_page_number,
    input  logic        dirty_in,
    input  logic [31:0] virtual_address,
`ifdef TLB_DIRTY_OUT_EN
    output logic        tlb_dirty,
`endif
    output logic        tlb_hit,
    output logic [31:0] physical_address
);
    logic [PTR_W-1:0]              ptr;
    logic [ENTRIES-1:0]            lk_match;
    logic [ENTRIES-1:0]            wr_match;
    logic [ENTRIES-1:0]            upd_sel;
    logic [ENTRIES-1:0]            alloc_sel;
    logic [ENTRIES-1:0][19:0]      ppn_vec;
    logic [ENTRIES-1:0]            dirty_vec;
    logic                          any_wr_match;
    logic                          hit;
    logic [19:0]                   sel_ppn;
    logic                          sel_dirty;

    // Pick the single entry to update in place (lowest index, defensively).
    always_comb begin
        upd_sel      = '0;
        any_wr_match = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (wr_match[i] && !any_wr_match) begin
                upd_sel[i]   = we;
                any_wr_match = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_ent
            assign alloc_sel[g] = we && !any_wr_match && (ptr == PTR_W'(g));

            tlb_entry u_ent (
                .clk      (clk),
                .reset    (reset),
                .alloc    (alloc_sel[g]),
                .update   (upd_sel[g]),
                .wr_vpn   (virtual_page_number),
                .wr_ppn   (physical_page_number),
                .wr_dirty (dirty_in),
                .lk_vpn   (virtual_address[31:12]),
                .lk_match (lk_match[g]),
                .wr_match (wr_match[g]),
                .ppn_q    (ppn_vec[g]),
                .dirty_q  (dirty_vec[g])
            );
        end
    endgenerate

    // Round-robin pointer advances only when a new VPN is allocated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (we && !any_wr_match) begin
            if (ptr == PTR_W'(ENTRIES - 1))
                ptr <= '0;
            else
                ptr <= ptr + 1'b1;
        end
    end

    // Lookup mux: scan high-to-low so the lowest matching index wins.
    always_comb begin
        hit       = 1'b0;
        sel_ppn   = '0;
        sel_dirty = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lk_match[i]) begin
                hit       = 1'b1;
                sel_ppn   = ppn_vec[i];
                sel_dirty = dirty_vec[i];
            end
        end
    end

    assign tlb_hit          = hit;
    assign physical_address = hit ? {sel_ppn, virtual_address[11:0]} : 32'h0;

`ifdef TLB_DIRTY_OUT_EN
    assign tlb_dirty = sel_dirty;
`else
    // Dirty is stored but has no consumer in this build.
    logic unused_dirty;
    assign unused_dirty = sel_dirty;
`endif
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed vectors with hand-computed expectations for tlb_unit.
module tb_tlb_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [19:0] virtual_page_number = '0;
    logic [19:0] physical_page_number = '0;
    logic        dirty_in = 1'b0;
    logic [31:0] virtual_address = '0;
    logic        tlb_hit;
    logic [31:0] physical_address;
`ifdef TLB_DIRTY_OUT_EN
    logic        tlb_dirty;
`endif

    int errs = 0;
    int checks = 0;

    tlb_unit #(.ENTRIES(8), .PTR_W(3)) dut (
        .clk                  (clk),
        .reset                (reset),
        .we                   (we),
        .virtual_page_number  (virtual_page_number),
        .physical_page_number (physical_page_number),
        .dirty_in             (dirty_in),
        .virtual_address      (virtual_address),
`ifdef TLB_DIRTY_OUT_EN
        .tlb_dirty            (tlb_dirty),
`endif
        .tlb_hit              (tlb_hit),
        .physical_address     (physical_address)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One write, launched and retired on falling edges.
    task automatic wr(input logic [19:0] vpn, input logic [19:0] ppn, input logic d);
        @(negedge clk);
        we = 1'b1;
        virtual_page_number  = vpn;
        physical_page_number = ppn;
        dirty_in = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] va, input logic h, input logic [31:0] pa);
        virtual_address = va;
        #1;
        chk({tag, "_hit"}, {31'b0, tlb_hit}, {31'b0, h});
        chk({tag, "_pa"}, physical_address, pa);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset state
        repeat (2) @(negedge clk);
        look("rst_during", 32'hABC01000, 1'b0, 32'h0);
        reset = 1'b0;
        look("rst_after", 32'hABC01000, 1'b0, 32'h0);

        // 2: two fills and lookups
        wr(20'hABC01, 20'h12345, 1'b1);
        wr(20'hDEF02, 20'h67890, 1'b0);
        look("t2_a", 32'hABC01000, 1'b1, 32'h12345000);
        look("t2_b", 32'hDEF02FFF, 1'b1, 32'h67890FFF);
`ifdef TLB_DIRTY_OUT_EN
        look("t2_da", 32'hABC01000, 1'b1, 32'h12345000);
        chk("dirty_set", {31'b0, tlb_dirty}, 32'd1);
        look("t2_db", 32'hDEF02FFF, 1'b1, 32'h67890FFF);
        chk("dirty_clr", {31'b0, tlb_dirty}, 32'd0);
`endif

        // 3: miss, then new fill
        look("t3_miss", 32'h12345ABC, 1'b0, 32'h0);
        wr(20'hFED03, 20'h0FEDC, 1'b0);
        look("t3_hit", 32'hFED03123, 1'b1, 32'h0FEDC123);

        // No bypass: lookup of the VPN being written sees pre-write contents.
        @(negedge clk);
        we = 1'b1;
        virtual_page_number  = 20'h99999;
        physical_page_number = 20'h11111;
        virtual_address = 32'h99999000;
        #1;
        chk("nobyp_hit", {31'b0, tlb_hit}, 32'd0);
        @(negedge clk);
        we = 1'b0;
        look("byp_after", 32'h99999000, 1'b1, 32'h11111000);

        // 4: clean table, fill 8 then a 9th to evict VPN 0
        do_reset();
        for (int i = 0; i < 8; i++)
            wr(20'(i), 20'(i) + 20'h10000, 1'b0);
        look("vpn0_legal", 32'h00000ABC, 1'b1, 32'h10000ABC);
        wr(20'h00008, 20'h10008, 1'b0);
        look("vpn0_evict", 32'h00000ABC, 1'b0, 32'h0);
        look("vpn8_hit", 32'h00008123, 1'b1, 32'h10008123);
        for (int i = 1; i < 8; i++)
            look($sformatf("vpn%0d_keep", i), {20'(i), 12'h045}, 1'b1, {20'(i) + 20'h10000, 12'h045});

        // 5: pointer now at 1. Fill ABC01 (evicts VPN1, ptr->2), then update in place.
        wr(20'hABC01, 20'h12345, 1'b1);
        look("t5_fill", 32'hABC01777, 1'b1, 32'h12345777);
        wr(20'hABC01, 20'h55555, 1'b0);
        look("t5_upd", 32'hABC01777, 1'b1, 32'h55555777);
        look("t5_keep2", 32'h00002000, 1'b1, 32'h10002000);
        // Next new VPN must land in slot 2 (evicting VPN2), not slot 3.
        wr(20'h77777, 20'h88888, 1'b0);
        look("t5_ev2", 32'h00002000, 1'b0, 32'h0);
        look("t5_keep3", 32'h00003000, 1'b1, 32'h10003000);
        look("t5_new", 32'h77777001, 1'b1, 32'h88888001);

        // 6: async reset between edges; write during reset dropped
        virtual_address = 32'hABC01000;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_hit", {31'b0, tlb_hit}, 32'd0);
        chk("async_pa", physical_address, 32'h0);
`ifdef TLB_DIRTY_OUT_EN
        chk("async_dirty", {31'b0, tlb_dirty}, 32'd0);
`endif
        we = 1'b1;
        virtual_page_number  = 20'h44444;
        physical_page_number = 20'h33333;
        @(negedge clk);
        @(negedge clk);
        we = 1'b0;
        reset = 1'b0;
        look("rst_drop_wr", 32'h44444000, 1'b0, 32'h0);
        look("rst_cleared", 32'h77777000, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
